// File: rtl/bus_pkg.sv
// Shared definitions for the two-cache snooping bus: op encodings, responder
// FSM states and default block geometry.
package bus_pkg;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] B_READ  = 2'b10;
    localparam logic [1:0] B_WRITE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        SNOOP_WAIT,
        MEM_RD,
        MEM_WR,
        RESP
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Two-requester round-robin arbiter. The pointer names the port that wins a tie
// and flips every time a transaction completes.
module rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~ptr;
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = ptr ? 2'b10 : 2'b01;
    end
endmodule

// File: rtl/bus_mem_responder.sv
// Bus responder and main-memory owner for the two-cache MSI system.
// Optional build macro SNOOP_WB_EN: a snoop hit also writes the supplied block to memory.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_LAT   = 2,
    parameter int SNOOP_TMO = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [3:0]          req_op,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          grant,
    output logic [1:0]          resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic [1:0]          snoop_req,
    output logic [ADDR_W-1:0]   snoop_addr,
    input  logic [1:0]          snoop_ready,
    input  logic [1:0]          snoop_hit,
    input  logic [2*DATA_W-1:0] snoop_data
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 8;

    state_t              state;
    logic                win;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
`ifdef SNOOP_WB_EN
    logic                hit_q;
`endif

    logic [1:0]          elig;
    logic [1:0]          gnt;
    logic                rr_ptr;
    logic                win_idx;
    logic [1:0]          sel_op;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                ready_j;
    logic                hit_j;
    logic [DATA_W-1:0]   sdata_j;

    // Only block ops (op[1]=1) compete; ops 00/01 are invisible to the arbiter.
    assign elig = {req_valid[1] & req_op[3], req_valid[0] & req_op[1]};

    rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (elig),
        .advance (state == RESP),
        .gnt     (gnt),
        .ptr     (rr_ptr)
    );

    assign win_idx   = (elig == 2'b11) ? rr_ptr : elig[1];
    assign sel_op    = win_idx ? req_op[3:2] : req_op[1:0];
    assign sel_addr  = win_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign sel_wdata = win_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    // Snoop responses are only looked at on the port opposite the winner.
    assign ready_j = win ? snoop_ready[0] : snoop_ready[1];
    assign hit_j   = win ? snoop_hit[0]   : snoop_hit[1];
    assign sdata_j = win ? snoop_data[DATA_W-1:0] : snoop_data[2*DATA_W-1:DATA_W];

    assign snoop_addr = addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            win        <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            cnt        <= '0;
            grant      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            snoop_req  <= '0;
`ifdef SNOOP_WB_EN
            hit_q      <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            grant      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            snoop_req  <= '0;
            case (state)
                // The requester still holds req_valid while its response is out,
                // so nothing is accepted in that cycle.
                IDLE: if (elig != 2'b00 && resp_valid == 2'b00) begin
                    win     <= win_idx;
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    grant   <= gnt;
                    cnt     <= '0;
`ifdef SNOOP_WB_EN
                    hit_q   <= 1'b0;
`endif
                    state   <= (sel_op == B_READ) ? SNOOP : MEM_WR;
                end
                SNOOP: begin
                    snoop_req <= win ? 2'b01 : 2'b10;
                    cnt       <= '0;
                    state     <= SNOOP_WAIT;
                end
                SNOOP_WAIT: begin
                    if (ready_j && hit_j) begin
                        data_q <= sdata_j;
`ifdef SNOOP_WB_EN
                        hit_q  <= 1'b1;
`endif
                        state  <= RESP;
                    end else if (ready_j || cnt == CNT_W'(SNOOP_TMO - 1)) begin
                        cnt   <= '0;
                        state <= MEM_RD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEM_RD: begin
                    if (cnt == CNT_W'(MEM_LAT)) begin
                        data_q <= mem[addr_q];
                        state  <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEM_WR: begin
                    if (cnt == '0)
                        mem[addr_q] <= wdata_q;
                    if (cnt == CNT_W'(MEM_LAT)) begin
                        data_q <= wdata_q;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    resp_valid <= win ? 2'b10 : 2'b01;
                    resp_data  <= data_q;
                    cnt        <= '0;
`ifdef SNOOP_WB_EN
                    if (hit_q)
                        mem[addr_q] <= data_q;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed table, arbitration and
// reset sequences, then randomized traffic against a latency/memory model.
module tb_bus_mem_responder;
    localparam int ML  = 2;
    localparam int TMO = 4;
`ifdef SNOOP_WB_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [3:0]  req_op = '0;
    logic [11:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  grant;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  snoop_req;
    logic [5:0]  snoop_addr;
    logic [1:0]  snoop_ready = '0;
    logic [1:0]  snoop_hit = '0;
    logic [63:0] snoop_data = '0;

    int checks = 0;
    int failures = 0;
    logic [31:0] ref_mem [64];
    int ref_ptr;

    typedef struct {
        int          port;
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          mode;   // 0 never answer, 1 miss, 2 hit
        int          k;
        logic [31:0] sdata;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    bus_mem_responder #(.ADDR_W(6), .DATA_W(32), .MEM_LAT(ML), .SNOOP_TMO(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant),
        .resp_valid(resp_valid), .resp_data(resp_data), .snoop_req(snoop_req),
        .snoop_addr(snoop_addr), .snoop_ready(snoop_ready), .snoop_hit(snoop_hit),
        .snoop_data(snoop_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        ref_ptr = 0;
    endtask

    // Latency and data from the transaction rules alone.
    task automatic model(input logic [1:0] op, input logic [5:0] a, input logic [31:0] wd,
                         input int mode, input int k, input logic [31:0] sd,
                         output int lat, output logic [31:0] d);
        bit answered;
        answered = (mode != 0) && (k < TMO);
        if (op == 2'b11) begin
            lat = 3 + ML; d = wd; ref_mem[a] = wd;
        end else if (answered && mode == 2) begin
            lat = 4 + k; d = sd;
            if (WB) ref_mem[a] = sd;
        end else if (answered) begin
            lat = 5 + k + ML; d = ref_mem[a];
        end else begin
            lat = 4 + TMO + ML; d = ref_mem[a];
        end
        ref_ptr ^= 1;
    endtask

    task automatic do_txn(input int port, input logic [1:0] op, input logic [5:0] addr,
                          input logic [31:0] wd, input int mode, input int k,
                          input logic [31:0] sd, input bit noise,
                          output int lat, output logic [31:0] d);
        int s;
        int j;
        bit done;
        bit quiet;
        logic [1:0] pm;
        logic [1:0] jm;
        j = 1 - port; s = -1; done = 0; lat = -1; d = '0;
        pm = (port == 0) ? 2'b01 : 2'b10;
        jm = ~pm;
        req_op[2*port +: 2]     = op;
        req_addr[6*port +: 6]   = addr;
        req_wdata[32*port +: 32] = wd;
        snoop_hit[j]            = (mode == 2);
        snoop_data[32*j +: 32]  = sd;
        req_valid[port]         = 1'b1;
        for (int t = 1; t <= 60 && !done; t++) begin
            tick();
            if (t == 1) check("grant_t1", grant, pm);
            if (snoop_req != 2'b00 && s < 0) begin
                s = t;
                check("snoop_req_port", snoop_req, jm);
                check("snoop_addr", snoop_addr, addr);
            end
            snoop_ready[j] = (mode != 0 && s >= 0 && t == s + k);
            if (noise) begin
                snoop_ready[port] = 1'($urandom_range(1));
                snoop_hit[port] = 1'b1;
                snoop_data[32*port +: 32] = $urandom;
            end
            if (resp_valid != 2'b00) begin
                lat = t; d = resp_data; done = 1;
                check("resp_port", resp_valid, pm);
            end
        end
        check("txn_completed", 64'(done), 64'd1);
        quiet = 1;
        tick();
        if (grant != 2'b00) quiet = 0;
        req_valid[port] = 1'b0;
        snoop_ready = '0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (grant != 2'b00 || resp_valid != 2'b00) quiet = 0;
        end
        check("quiet_after_resp", 64'(quiet), 64'd1);
    endtask

    // Both ports issue reads together; snoops are answered at once as misses.
    task automatic arb_pair(output int first, output int second);
        int order [2];
        int n;
        logic [1:0] drop;
        n = 0; drop = '0; order[0] = -1; order[1] = -1;
        req_op = 4'b1010; req_addr = {6'h22, 6'h11}; snoop_hit = '0;
        req_valid = 2'b11;
        for (int t = 1; t <= 80 && n < 2; t++) begin
            tick();
            req_valid = req_valid & ~drop;
            drop = '0;
            snoop_ready = snoop_req;
            if (resp_valid[0]) begin order[n] = 0; n++; drop[0] = 1'b1; end
            else if (resp_valid[1]) begin order[n] = 1; n++; drop[1] = 1'b1; end
        end
        tick();
        req_valid = '0; snoop_ready = '0;
        repeat (2) tick();
        first = order[0]; second = order[1];
    endtask

    initial begin
        vec_t vecs [8];
        int lat, elat, f, s;
        logic [31:0] d, ed;
        bit quiet;
        int port, mode, k;
        logic [1:0] op;
        logic [5:0] addr;
        logic [31:0] wd, sd;

        vecs[0] = '{0, 2'b11, 6'h05, 32'hDEADBEEF, 0, 0, 32'h0, 5, 32'hDEADBEEF};
        vecs[1] = '{1, 2'b10, 6'h05, 32'h0, 1, 1, 32'h0, 8, 32'hDEADBEEF};
        vecs[2] = '{1, 2'b10, 6'h0A, 32'h0, 2, 2, 32'h12345678, 6, 32'h12345678};
        vecs[3] = '{0, 2'b10, 6'h0A, 32'h0, 0, 0, 32'h0, 10, WB ? 32'h12345678 : 32'h0};
        vecs[4] = '{0, 2'b10, 6'h3F, 32'h0, 1, 0, 32'h0, 7, 32'h0};
        vecs[5] = '{1, 2'b11, 6'h3F, 32'h0000A5A5, 0, 0, 32'h0, 5, 32'h0000A5A5};
        vecs[6] = '{1, 2'b10, 6'h3F, 32'h0, 2, 3, 32'hCAFEF00D, 7, 32'hCAFEF00D};
        vecs[7] = '{0, 2'b10, 6'h3F, 32'h0, 2, 4, 32'hBADBADBA, 10, WB ? 32'hCAFEF00D : 32'h0000A5A5};

        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        check("reset_outputs", {grant, resp_valid, snoop_req, snoop_addr, resp_data}, '0);

        // Simultaneous requests: pointer picks, then rotates back after two.
        for (int p = 0; p < 2; p++) begin
            arb_pair(f, s);
            check("arb_first", f, ref_ptr);
            check("arb_second", s, 1 - ref_ptr);
        end

        // Non-block ops are never granted.
        req_op = 4'b0001; req_valid = 2'b11; quiet = 1;
        repeat (8) begin
            tick();
            if (grant != 2'b00 || resp_valid != 2'b00) quiet = 0;
        end
        req_valid = '0; req_op = '0;
        check("ignored_ops", 64'(quiet), 64'd1);

        foreach (vecs[i]) begin
            do_txn(vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mode,
                   vecs[i].k, vecs[i].sdata, 1'b0, lat, d);
            model(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mode, vecs[i].k,
                  vecs[i].sdata, elat, ed);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        end

        // One single transaction moves the pointer to port 1 for the next tie.
        do_txn(0, 2'b11, 6'h20, 32'h00C0FFEE, 0, 0, 32'h0, 1'b0, lat, d);
        model(2'b11, 6'h20, 32'h00C0FFEE, 0, 0, 32'h0, elat, ed);
        check("rot_single_lat", lat, elat);
        arb_pair(f, s);
        check("rot_first", f, ref_ptr);
        check("rot_second", s, 1 - ref_ptr);

        for (int n = 0; n < 40; n++) begin
            port = $urandom_range(1);
            op   = $urandom_range(1) ? 2'b11 : 2'b10;
            addr = {3'b111, 3'($urandom_range(7))};
            wd   = $urandom;
            sd   = $urandom;
            mode = $urandom_range(2);
            k    = $urandom_range(5);
            do_txn(port, op, addr, wd, mode, k, sd, 1'b1, lat, d);
            model(op, addr, wd, mode, k, sd, elat, ed);
            check("rand_lat", lat, elat);
            check("rand_data", d, ed);
        end

        // Reset while in MEM_RD drops the read and clears memory.
        req_op[1:0] = 2'b10; req_addr[5:0] = 6'h05; snoop_hit = '0; req_valid[0] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            snoop_ready = snoop_req;
        end
        reset = 1'b1; req_valid = '0; snoop_ready = '0;
        tick();
        check("reset_mid_outputs", {grant, resp_valid, snoop_req, snoop_addr, resp_data}, '0);
        reset = 1'b0;
        quiet = 1;
        repeat (10) begin
            tick();
            if (resp_valid != 2'b00) quiet = 0;
        end
        check("no_resp_after_reset", 64'(quiet), 64'd1);
        model_reset();
        do_txn(1, 2'b10, 6'h05, 32'h0, 1, 1, 32'h0, 1'b0, lat, d);
        model(2'b10, 6'h05, 32'h0, 1, 1, 32'h0, elat, ed);
        check("post_reset_lat", lat, elat);
        check("post_reset_data", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Shared-bus responder and main-memory model for the two-cache MSI snooping system. It accepts block-level bus reads (op 2'b10) and write-backs (op 2'b11) from two cache ports and arbitrates between them round-robin. For a read, it first snoops the other cache and returns the other cache's block on a snoop hit; otherwise it returns the block from its internal 64-entry memory after a fixed latency. It sits between the cache datapaths' bus side and the rest of the system, and is the single owner of main memory.

## Interface
Parameters:
- ADDR_W, 6, block address width ({tag, index}); memory depth is 2**ADDR_W
- DATA_W, 32, block width
- MEM_LAT, 2, memory access cycles, minimum 1
- SNOOP_TMO, 4, maximum cycles to wait for snoop_ready before treating the snoop as a miss

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-port request, held until that port's resp_valid
- req_op  in  4  {op1, op0}; 2'b10 = b_read, 2'b11 = b_write
- req_addr  in  2*ADDR_W  per-port block address
- req_wdata  in  2*DATA_W  per-port write-back data
- grant  out  2  one-cycle pulse to the winning port
- resp_valid  out  2  one-cycle completion pulse
- resp_data  out  DATA_W  read data; for a write, the written data
- snoop_req  out  2  one-cycle snoop strobe to the non-requesting port
- snoop_addr  out  ADDR_W  snooped block address, valid while in SNOOP or SNOOP_WAIT
- snoop_ready  in  2  per-port snoop response strobe
- snoop_hit  in  2  per-port hit, sampled with snoop_ready
- snoop_data  in  2*DATA_W  per-port supplied block, sampled with snoop_ready

## Operation
- States and transitions:
  - IDLE: wait for a request.
  - SNOOP: drive snoop_req for one cycle.
  - SNOOP_WAIT: wait for the snooped port's response.
  - MEM_RD: memory read latency.
  - MEM_WR: memory write latency.
  - RESP: complete the transaction.
- IDLE, request handling:
  - A port is eligible when req_valid=1 and op[1]=1. Ops 2'b00 and 2'b01 are ignored; they are never granted and never flagged.
  - One eligible port wins; with two eligible ports, the round-robin pointer picks.
  - The winner's op, addr and wdata are latched. grant pulses on the next cycle.
  - b_read goes to SNOOP; b_write goes to MEM_WR.
- SNOOP:
  - snoop_req[j]=1, where j is the other port. snoop_addr = latched addr.
  - Always goes to SNOOP_WAIT.
- SNOOP_WAIT (timeout counter starts at 0):
  - snoop_ready[j]=1 with snoop_hit[j]=1: latch snoop_data[j] as the response and go to RESP.
  - snoop_ready[j]=1 with snoop_hit[j]=0: go to MEM_RD.
  - Counter reaches SNOOP_TMO: treat as a miss and go to MEM_RD.
- MEM_RD: count MEM_LAT cycles, then latch mem[addr] and go to RESP.
- MEM_WR:
  - mem[addr] <= wdata on the entry cycle.
  - Count MEM_LAT cycles, then go to RESP.
- RESP:
  - resp_valid[winner]=1 for one cycle, with resp_data.
  - The round-robin pointer moves to the other port.
  - Go to IDLE.
- One transaction at a time. Requests arriving while busy wait; req_valid must stay asserted.
- A winner that drops req_valid mid-transaction does not abort it; the response is still issued.
- snoop_ready is ignored outside SNOOP_WAIT, and on the non-snooped port.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, round-robin pointer to port 0, counters 0.
  - Every memory word 0.
- Reset mid-transaction drops the transaction: no resp_valid is issued. A memory write already performed is cleared by the memory reset.
- Latency, counted from the request's first cycle (T0) to resp_valid:
  - Write: 3+MEM_LAT cycles.
  - Read with snoop hit, snoop_ready k cycles after snoop_req: 4+k cycles.
  - Read with snoop miss: 5+k+MEM_LAT cycles.
  - Read with snoop timeout: 4+SNOOP_TMO+MEM_LAT cycles.
- Address arithmetic wraps modulo 2**ADDR_W; no bounds checking.
- A request presented in the same cycle as resp_valid is seen at IDLE in the next cycle; there is no back-to-back bypass.

## Configuration
- SNOOP_WB_EN defined: on a snoop hit, mem[addr] is also written with the supplied snoop_data in the RESP cycle, so an M-state owner transfer also updates memory.
- SNOOP_WB_EN undefined: memory is not updated on a snoop hit. Memory changes only on b_write.

## Structure
- Package bus_pkg holds:
  - op encodings B_READ=2'b10 and B_WRITE=2'b11.
  - the state enum {IDLE, SNOOP, SNOOP_WAIT, MEM_RD, MEM_WR, RESP}.
  - default constants for ADDR_W and DATA_W.
- Sub-module rr_arbiter: two-requester round-robin. Inputs req[1:0] and advance. Outputs one-hot gnt and the pointer.

## Test plan
- Write port 0, addr 6'h05, data 32'hDEADBEEF, MEM_LAT=2 -> grant[0] at T1, resp_valid[0] at T5; a subsequent read of 6'h05 from port 1, with snoop miss, returns 32'hDEADBEEF.
- Read port 1, addr 6'h0A; port 0 answers snoop_ready with snoop_hit=1 and data 32'h12345678 two cycles after snoop_req -> resp_data=32'h12345678 at T6. With SNOOP_WB_EN, mem[6'h0A]=32'h12345678; without it, mem[6'h0A] is unchanged.
- Both ports request reads in the same cycle after reset -> port 0 is served first, then port 1; a third simultaneous pair is again served port 0 first, confirming pointer rotation.
- Read with snoop_ready never asserted, SNOOP_TMO=4, MEM_LAT=2 -> resp_valid at T10 carrying the memory data.
- req_op=2'b01 on port 0 -> no grant, no resp_valid, state stays IDLE.
- reset asserted in MEM_RD -> next cycle all outputs are 0 and no resp_valid is issued; a read of any address afterwards returns 0.
